huffman_bit_aligner: RTL and testbench

- Parametrised bitstream front-end for the Huffman decoder.
- Accepts packed IN_W-bit words MSB-first and holds them in a left-aligned bit buffer.
- Presents a WIN_W-bit lookahead window and removes a variable number of bits (0..WIN_W) per cycle on consumer request.
- Replaces the ad-hoc shift register that fed 6-bit windows. Adds configurable widths, input backpressure, end-of-stream drain and error detection.

---
 rtl/huffman_bit_aligner.sv | 146 ++++++++++++++
 tb/tb_huffman_bit_aligner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_aligner.sv
// ---------------------------------------------------------------------------
// huffman_bit_aligner
//
// Bitstream front-end for the Huffman decoder. Packed IN_W-bit words arrive
// MSB-first and are appended to a left-aligned bit buffer. The top WIN_W
// buffer bits form a lookahead window. The consumer drops 0..WIN_W bits per
// cycle from the front of that window.
//
// Optional feature: define HUFF_ALIGN_STATS_EN to add the total_bits and
// sym_count statistics outputs.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   in_data      packed input word; bit IN_W-1 is the first stream bit
//   in_valid     in_data valid
//   in_last      final word of the stream (qualified by in_valid)
//   in_ready     buffer can accept a word this cycle
//   win_data     next WIN_W stream bits, MSB = oldest, zero-padded past data
//   win_valid    window usable
//   avail        number of bits currently held
//   consume      consumer strobe
//   consume_len  number of bits to drop when consume = 1
//   done         last word received and buffer empty
//   err          sticky overconsume error
//   total_bits   (HUFF_ALIGN_STATS_EN) legally consumed bits since reset
//   sym_count    (HUFF_ALIGN_STATS_EN) legal consumes with nonzero length
// ---------------------------------------------------------------------------
module huffman_bit_aligner #(
    parameter int IN_W  = 32,
    parameter int WIN_W = 10,
    parameter int LEN_W = 4,
    parameter int BUF_W = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_valid,
    output logic [CNT_W-1:0] avail,
    input  logic             consume,
    input  logic [LEN_W-1:0] consume_len,
    output logic             done,
    output logic             err
`ifdef HUFF_ALIGN_STATS_EN
    ,
    output logic [31:0]      total_bits,
    output logic [31:0]      sym_count
`endif
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] len_ext;
    logic             overconsume;
    logic             legal;
    logic             accept;
    logic [CNT_W-1:0] shamt;
    logic [CNT_W-1:0] cnt_kept;
    logic [BUF_W-1:0] bits_kept;
    logic [BUF_W-1:0] in_word;

    // Headroom check uses the registered count only, one bit wider so the
    // sum cannot wrap.
    assign in_ready  = (state_q == S_FILL) &&
                       (({1'b0, cnt_q} + (CNT_W+1)'(IN_W)) <= (CNT_W+1)'(BUF_W));
    assign win_data  = bits_q[BUF_W-1 -: WIN_W];
    assign win_valid = (state_q == S_DRAIN) ||
                       ((state_q == S_FILL) && (cnt_q >= CNT_W'(WIN_W)));
    assign avail     = cnt_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

    assign len_ext     = CNT_W'(consume_len);
    assign overconsume = consume && ((len_ext > cnt_q) ||
                                     (consume_len > LEN_W'(WIN_W)));
    assign legal       = consume && !overconsume;
    assign accept      = in_valid && in_ready;

    // An illegal request drops nothing; the shift amount is forced to zero.
    assign shamt     = legal ? len_ext : '0;
    assign cnt_kept  = cnt_q - shamt;
    assign bits_kept = bits_q << shamt;
    assign in_word   = {in_data, {(BUF_W-IN_W){1'b0}}};

    always_comb begin
        bits_d  = bits_kept;
        cnt_d   = cnt_kept;
        state_d = state_q;
        err_d   = err_q | overconsume;
        // Bits below the kept region are zero, so OR-ing the new word in
        // right behind them appends it without masking.
        if (accept) begin
            bits_d = bits_kept | (in_word >> cnt_kept);
            cnt_d  = cnt_kept + CNT_W'(IN_W);
        end
        case (state_q)
            S_FILL:  if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == '0)       state_d = S_DONE;
            default: state_d = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_FILL;
            err_q   <= 1'b0;
        end else begin
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

`ifdef HUFF_ALIGN_STATS_EN
    logic [31:0] total_q, sym_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
            sym_q   <= '0;
        end else if (legal) begin
            total_q <= total_q + 32'(shamt);
            if (consume_len != '0) sym_q <= sym_q + 32'd1;
        end
    end

    assign total_bits = total_q;
    assign sym_count  = sym_q;
`endif

endmodule

// File: tb/tb_huffman_bit_aligner.sv
module tb_huffman_bit_aligner;

    localparam int IN_W  = 32;
    localparam int WIN_W = 10;
    localparam int LEN_W = 4;
    localparam int BUF_W = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [WIN_W-1:0] win_data;
    logic             win_valid;
    logic [CNT_W-1:0] avail;
    logic             consume = 1'b0;
    logic [LEN_W-1:0] consume_len = '0;
    logic             done;
    logic             err;
`ifdef HUFF_ALIGN_STATS_EN
    logic [31:0]      total_bits;
    logic [31:0]      sym_count;
`endif

    huffman_bit_aligner #(
        .IN_W(IN_W), .WIN_W(WIN_W), .LEN_W(LEN_W), .BUF_W(BUF_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .win_data(win_data), .win_valid(win_valid), .avail(avail),
        .consume(consume), .consume_len(consume_len),
        .done(done), .err(err)
`ifdef HUFF_ALIGN_STATS_EN
        , .total_bits(total_bits), .sym_count(sym_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the stream is a plain queue of bits, oldest first.
    bit          mq[$];
    bit          m_last;
    bit          m_err;
    logic [31:0] m_total;
    logic [31:0] m_sym;

    function automatic bit m_ready();
        return !m_last && (mq.size() + IN_W <= BUF_W);
    endfunction

    function automatic logic [WIN_W-1:0] m_win();
        logic [WIN_W-1:0] w = '0;
        for (int i = 0; i < WIN_W; i++)
            if (i < mq.size()) w[WIN_W-1-i] = mq[i];
        return w;
    endfunction

    function automatic bit m_wvalid();
        return m_last ? (mq.size() > 0) : (mq.size() >= WIN_W);
    endfunction

    task automatic m_clear();
        mq.delete();
        m_last  = 0;
        m_err   = 0;
        m_total = '0;
        m_sym   = '0;
    endtask

    task automatic check_all();
        chk("in_ready",  64'(in_ready),  64'(m_ready()));
        chk("win_valid", 64'(win_valid), 64'(m_wvalid()));
        chk("win_data",  64'(win_data),  64'(m_win()));
        chk("avail",     64'(avail),     64'(mq.size()));
        chk("done",      64'(done),      64'(m_last && mq.size() == 0));
        chk("err",       64'(err),       64'(m_err));
`ifdef HUFF_ALIGN_STATS_EN
        chk("total_bits", 64'(total_bits), 64'(m_total));
        chk("sym_count",  64'(sym_count),  64'(m_sym));
`endif
    endtask

    // Called at a negedge: applies one cycle of stimulus, advances the model,
    // and checks the new state at the following negedge.
    task automatic step(input logic v, input logic l, input logic [IN_W-1:0] d,
                        input logic c, input logic [LEN_W-1:0] n);
        bit acc, lg;
        in_valid = v; in_last = l; in_data = d; consume = c; consume_len = n;
        acc = v && m_ready();
        lg  = c && (n <= mq.size()) && (n <= WIN_W);
        if (lg) begin
            for (int i = 0; i < int'(n); i++) void'(mq.pop_front());
            m_total = m_total + 32'(n);
            if (n != 0) m_sym = m_sym + 1;
        end else if (c) begin
            m_err = 1;
        end
        if (acc) begin
            for (int i = IN_W-1; i >= 0; i--) mq.push_back(d[i]);
            if (l) m_last = 1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_last = 0; in_data = '0; consume = 0; consume_len = '0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 0;
        in_valid = 0; in_last = 0; in_data = '0; consume = 0; consume_len = '0;
        #1;
        m_clear();
        chk("rst_avail",    64'(avail),     64'd0);
        chk("rst_in_ready", 64'(in_ready),  64'd1);
        chk("rst_wvalid",   64'(win_valid), 64'd0);
        chk("rst_done",     64'(done),      64'd0);
        chk("rst_win",      64'(win_data),  64'd0);
        chk("rst_err",      64'(err),       64'd0);
        @(negedge clk);
        rst = 1;
        check_all();
    endtask

    initial begin
        m_clear();
        repeat (2) @(negedge clk);

        // Single all-ones push
        do_reset();
        chk("t1_ready_before", 64'(in_ready), 64'd1);
        step(1, 0, 32'hFFFF_FFFF, 0, 0);
        chk("t1_avail", 64'(avail),     64'd32);
        chk("t1_wv",    64'(win_valid), 64'd1);
        chk("t1_win",   64'(win_data),  64'h3FF);

        // Window walk over 0xA5000000
        do_reset();
        step(1, 0, 32'hA500_0000, 0, 0);
        chk("t2_win0", 64'(win_data), 64'h294);
        chk("t2_av0",  64'(avail),    64'd32);
        step(0, 0, '0, 1, 4);
        chk("t2_win1", 64'(win_data), 64'h140);
        chk("t2_av1",  64'(avail),    64'd28);
        step(0, 0, '0, 1, 4);
        chk("t2_win2", 64'(win_data), 64'h000);
        chk("t2_av2",  64'(avail),    64'd24);

        // Backpressure at 40 bits
        do_reset();
        step(1, 0, 32'h1234_5678, 0, 0);
        step(0, 0, '0, 1, 10);
        step(0, 0, '0, 1, 10);
        step(0, 0, '0, 1, 4);
        step(1, 0, 32'h9ABC_DEF0, 0, 0);
        chk("t3_av40",   64'(avail),    64'd40);
        chk("t3_notrdy", 64'(in_ready), 64'd0);
        step(1, 0, 32'hCAFE_F00D, 1, 10);
        chk("t3_av30",   64'(avail),    64'd30);
        chk("t3_rdy",    64'(in_ready), 64'd1);
        step(1, 0, 32'hCAFE_F00D, 0, 0);
        chk("t3_av62",   64'(avail),    64'd62);

        // Drain to done
        do_reset();
        step(1, 1, 32'hC000_0000, 0, 0);
        chk("t4_win",  64'(win_data),  64'h300);
        chk("t4_nrdy", 64'(in_ready),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 1, 10);
            chk("t4_wv", 64'(win_valid), 64'd1);
        end
        chk("t4_tailwin", 64'(win_data), 64'h000);
        step(0, 0, '0, 1, 2);
        chk("t4_av",   64'(avail),    64'd0);
        chk("t4_done", 64'(done),     64'd1);
        chk("t4_rdy",  64'(in_ready), 64'd0);
        step(1, 0, 32'hFFFF_FFFF, 0, 0);
        chk("t4_hold", 64'(done), 64'd1);

        // Overconsume
        do_reset();
        step(1, 0, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, '0, 1, 10);
        step(0, 0, '0, 1, 10);
        step(0, 0, '0, 1, 9);
        chk("t5_av3",  64'(avail),    64'd3);
        step(0, 0, '0, 1, 5);
        chk("t5_err",  64'(err),      64'd1);
        chk("t5_av",   64'(avail),    64'd3);
        chk("t5_win",  64'(win_data), 64'h380);
        step(0, 0, '0, 1, 2);
        chk("t5_sticky", 64'(err), 64'd1);
        step(1, 0, 32'h0F0F_0F0F, 1, 11);
        chk("t5_acc_on_err", 64'(avail), 64'd33);
        do_reset();
        chk("t5_cleared", 64'(err), 64'd0);

`ifdef HUFF_ALIGN_STATS_EN
        do_reset();
        step(1, 0, 32'h1357_9BDF, 0, 0);
        step(0, 0, '0, 1, 4);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 6);
        step(0, 0, '0, 1, 15);
        chk("st_total", 64'(total_bits), 64'd10);
        chk("st_sym",   64'(sym_count),  64'd2);
`endif

        // Randomized episodes, each started by an asynchronous reset
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 300; cyc++) begin
                logic v, l, c;
                logic [LEN_W-1:0] n;
                v = ($urandom_range(0, 99) < 45);
                l = ($urandom_range(0, 99) < 3);
                c = ($urandom_range(0, 99) < 60);
                n = ($urandom_range(0, 99) < 5) ? LEN_W'($urandom_range(11, 15))
                                                : LEN_W'($urandom_range(0, 10));
                step(v, l, $urandom, c, n);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
